seq_game_engine: RTL and testbench
==================================

Name: seq_game_engine

Overview:
- Parametrised Simon-style sequence engine; successor of the fixed 2-bit, fixed-length random_generator/player pair.
- Generates a pseudo-random tile sequence and replays it as timed flash requests for graphics_control.
- Checks player key presses against the stored sequence and grows the sequence one tile per completed round until MAX_LEN (win) or the first mistake or timeout (lose).
- Sits between the top-level key/switch inputs and the graphics/tile_LUT path.

Parameters:
- TILE_W, 2, bits per tile ID (2**TILE_W tiles).
- MAX_LEN, 16, sequence storage depth and winning length, range 2..64.
- LEN_W, 7, width of length/index fields; must hold MAX_LEN.
- ON_CYCLES, 25000000, cycles a tile stays lit during playback, >=1.
- OFF_CYCLES, 12500000, dark gap after each lit tile and before each replay, >=1.
- TIMEOUT_CYCLES, 0, maximum cycles allowed between player keys; 0 disables the timeout.
- SEED, 16'hACE1, LFSR reset value, nonzero.

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a game; honoured only in IDLE, WIN or LOSE.
- start_len  in  LEN_W  initial sequence length; clamped to the range 1..MAX_LEN.
- key_valid  in  1  one-cycle pulse for a player press; debounced and edge-detected upstream.
- key_tile  in  TILE_W  tile ID pressed; valid with key_valid.
- flash_valid  out  1  high while a tile must be drawn lit.
- flash_tile  out  TILE_W  tile to draw; 0 when flash_valid=0.
- player_turn  out  1  high in WAIT_KEY.
- level  out  LEN_W  current sequence length.
- win  out  1  high in WIN.
- lose  out  1  high in LOSE.

Behaviour:
- Reset (overrides everything, in any state): state=IDLE, LFSR=SEED, len=0, idx=0, timers=0; all outputs 0. The sequence memory contents are don't-care.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every non-reset cycle in every state. A new tile is LFSR[TILE_W-1:0] sampled on the cycle it is written.
- Memory: MAX_LEN x TILE_W register array.
- All outputs are registered or decoded from registered state. level = len.
- IDLE:
  - start=1 -> len=clamp(start_len), idx=0, go to GEN.
- GEN:
  - Writes mem[idx]=tile and idx++ each cycle; occupies exactly len cycles.
  - Then idx=0 and go to SHOW_ON.
  - flash_valid rises on the first cycle after the last GEN cycle.
- SHOW_ON:
  - flash_valid=1, flash_tile=mem[idx], for exactly ON_CYCLES cycles, then go to SHOW_OFF.
- SHOW_OFF:
  - Outputs dark for exactly OFF_CYCLES cycles.
  - Then, if idx==len-1: idx=0, go to WAIT_KEY; otherwise idx++, go to SHOW_ON.
- WAIT_KEY:
  - player_turn=1; timeout counter runs.
  - key_valid with key_tile==mem[idx] and idx<len-1: idx++, timeout counter cleared.
  - key_valid matching with idx==len-1, len==MAX_LEN: go to WIN.
  - key_valid matching with idx==len-1, len<MAX_LEN: go to APPEND.
  - key_valid with a mismatch: go to LOSE.
  - TIMEOUT_CYCLES!=0 and no key for TIMEOUT_CYCLES cycles since entering WAIT_KEY or since the last accepted key: go to LOSE.
- APPEND (1 cycle):
  - mem[len]=tile, len++, idx=0.
  - Then go to SHOW_OFF-gap: OFF_CYCLES dark, then SHOW_ON from idx 0, with no index increment.
- WIN / LOSE:
  - Hold win=1 or lose=1; len is retained.
  - start=1 behaves exactly as in IDLE (a new game; the flag drops on the next cycle).
- Ignored inputs:
  - key_valid outside WAIT_KEY is ignored and never buffered.
  - start outside IDLE/WIN/LOSE is ignored; in WAIT_KEY, a key_valid in the same cycle is still processed.
- start_len=0 yields len=1; start_len>MAX_LEN yields len=MAX_LEN.
- win, lose and player_turn are mutually exclusive; flash_valid=1 only in SHOW_ON.

Test Plan:
- Reset mid-SHOW_ON (ON=4, OFF=2, MAX_LEN=4): assert reset -> next cycle state IDLE, flash_valid=0, level=0, win=lose=0.
- Playback timing (ON=4, OFF=2), start with start_len=3:
  - flash_valid rises exactly 4 cycles after the start cycle (3 GEN + 1).
  - Then 3 pulses of 4 cycles high / 2 low.
  - player_turn=1 on the cycle after the final gap.
- Full win (MAX_LEN=4, start_len=2): bench replays every captured flash_tile -> level steps 2->3->4, after the 4th correct key win=1, player_turn=0.
- Wrong key: in WAIT_KEY press (mem[0]+1) mod 4 -> lose=1 next cycle; a later key_valid leaves lose=1.
- Timeout (TIMEOUT_CYCLES=10), no keys: lose=1 exactly 10 cycles after player_turn rises; 1 correct key at cycle 9 restarts the 10-cycle count.
- Clamp/ignore checks:
  - start_len=0 -> level=1; start_len=9 with MAX_LEN=4 -> level=4.
  - key_valid during SHOW_ON and start during WAIT_KEY have no effect.
  - A second start from LOSE restarts the game, with GEN using fresh LFSR values.

Source files
------------

// File: rtl/seq_game_engine.sv
// ---------------------------------------------------------------------------
// seq_game_engine
//
// Simon-style sequence engine. It generates a pseudo-random tile sequence,
// replays it as timed flash requests for the graphics path, then checks the
// player's key presses against it. Each completed round appends one tile
// until MAX_LEN is reached (win). A wrong key or a timeout ends the game
// (lose).
//
// Handshake note: start and key_valid are single-cycle strobes with no ready
// path. start is only honoured in IDLE/WIN/LOSE. key_valid is only honoured
// in WAIT_KEY. Strobes arriving in any other state are dropped, not queued.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   start        pulse that begins a game (IDLE/WIN/LOSE only)
//   start_len    initial sequence length, clamped to 1..MAX_LEN
//   key_valid    pulse for one player press
//   key_tile     tile pressed, qualified by key_valid
//   flash_valid  tile must be drawn lit (SHOW_ON only)
//   flash_tile   tile to draw, 0 when flash_valid is low
//   player_turn  engine is waiting for player keys
//   level        current sequence length
//   win / lose   end-of-game flags, held until the next start
//   dbg_state    current FSM state, exposed for checkers
// ---------------------------------------------------------------------------
module seq_game_engine #(
    parameter int          TILE_W         = 2,
    parameter int          MAX_LEN        = 16,
    parameter int          LEN_W          = 7,
    parameter int          ON_CYCLES      = 25000000,
    parameter int          OFF_CYCLES     = 12500000,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  start_len,
    input  logic              key_valid,
    input  logic [TILE_W-1:0] key_tile,
    output logic              flash_valid,
    output logic [TILE_W-1:0] flash_tile,
    output logic              player_turn,
    output logic [LEN_W-1:0]  level,
    output logic              win,
    output logic              lose,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF,
        S_WAIT_KEY, S_APPEND, S_WIN, S_LOSE
    } state_t;

    localparam int               MEM_AW    = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);
    localparam logic [31:0]      ON_LAST   = 32'(ON_CYCLES - 1);
    localparam logic [31:0]      OFF_LAST  = 32'(OFF_CYCLES - 1);
    localparam logic [31:0]      TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [TILE_W-1:0]   mem [MAX_LEN];
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    idx;
    logic [LEN_W-1:0]    start_len_c;
    logic [31:0]         timer;
    // Set by APPEND: the next SHOW_OFF is the pre-replay gap and must fall
    // through to SHOW_ON at idx 0 without the usual index step.
    logic                replay_gap;

    logic [TILE_W-1:0]   new_tile;
    logic [MEM_AW-1:0]   idx_a;
    logic [MEM_AW-1:0]   idx_inc_a;
    logic [MEM_AW-1:0]   len_a;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_waddr;
    logic                last_idx;

    // Galois LFSR, x^16 + x^14 + x^13 + x^11, shifting right.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign new_tile  = lfsr[TILE_W-1:0];

    // idx and len are below MAX_LEN wherever they address memory.
    assign idx_a     = idx[MEM_AW-1:0];
    assign idx_inc_a = idx_a + 1'b1;
    assign len_a     = len[MEM_AW-1:0];
    assign last_idx  = (idx == len - ONE_L);

    assign level     = len;
    assign dbg_state = state;

    always_comb begin
        if (start_len == '0) begin
            start_len_c = ONE_L;
        end else if (start_len > MAX_LEN_L) begin
            start_len_c = MAX_LEN_L;
        end else begin
            start_len_c = start_len;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx_a;
        if (state == S_GEN) begin
            mem_we = 1'b1;
        end else if (state == S_APPEND) begin
            mem_we    = 1'b1;
            mem_waddr = len_a;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= new_tile;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            lfsr        <= SEED;
            len         <= '0;
            idx         <= '0;
            timer       <= '0;
            replay_gap  <= 1'b0;
            flash_valid <= 1'b0;
            flash_tile  <= '0;
            player_turn <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state <= S_GEN;
                        len   <= start_len_c;
                        idx   <= '0;
                        timer <= '0;
                        win   <= 1'b0;
                        lose  <= 1'b0;
                    end
                end
                S_GEN: begin
                    if (last_idx) begin
                        state       <= S_SHOW_ON;
                        idx         <= '0;
                        timer       <= '0;
                        flash_valid <= 1'b1;
                        // With len==1, mem[0] is being written on this edge.
                        flash_tile  <= (idx == '0) ? new_tile : mem[0];
                    end else begin
                        idx <= idx + ONE_L;
                    end
                end
                S_SHOW_ON: begin
                    if (timer == ON_LAST) begin
                        state       <= S_SHOW_OFF;
                        timer       <= '0;
                        flash_valid <= 1'b0;
                        flash_tile  <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_SHOW_OFF: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (replay_gap) begin
                            replay_gap  <= 1'b0;
                            state       <= S_SHOW_ON;
                            flash_valid <= 1'b1;
                            flash_tile  <= mem[0];
                        end else if (last_idx) begin
                            idx         <= '0;
                            state       <= S_WAIT_KEY;
                            player_turn <= 1'b1;
                        end else begin
                            idx         <= idx + ONE_L;
                            state       <= S_SHOW_ON;
                            flash_valid <= 1'b1;
                            flash_tile  <= mem[idx_inc_a];
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_WAIT_KEY: begin
                    if (key_valid) begin
                        if (key_tile != mem[idx_a]) begin
                            state       <= S_LOSE;
                            player_turn <= 1'b0;
                            lose        <= 1'b1;
                        end else if (!last_idx) begin
                            idx   <= idx + ONE_L;
                            timer <= '0;
                        end else if (len == MAX_LEN_L) begin
                            state       <= S_WIN;
                            player_turn <= 1'b0;
                            win         <= 1'b1;
                        end else begin
                            state       <= S_APPEND;
                            player_turn <= 1'b0;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (timer == TO_LAST) begin
                            state       <= S_LOSE;
                            player_turn <= 1'b0;
                            lose        <= 1'b1;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                end
                S_APPEND: begin
                    len        <= len + ONE_L;
                    idx        <= '0;
                    timer      <= '0;
                    replay_gap <= 1'b1;
                    state      <= S_SHOW_OFF;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_game_engine.sv
// ---------------------------------------------------------------------------
// tb_seq_game_engine
//
// Reference model: on each start it expands the whole game round into a
// queue of expected per-cycle outputs (dark GEN cycles, lit/dark playback
// pulses), then tracks the player phase as "expected index + cycles since
// last accepted key". One negedge process compares all outputs to the model
// every cycle. Directed scenarios add literal timing/level expectations.
// ---------------------------------------------------------------------------
module tb_seq_game_engine;

    localparam int TILE_W = 2;
    localparam int MAX_LEN = 4;
    localparam int LEN_W = 7;
    localparam int ON_C = 4;
    localparam int OFF_C = 2;
    localparam int TO_C = 10;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int EXP_W = 1 + TILE_W + 1 + 1 + 1 + LEN_W;

    localparam int MD_IDLE = 0;
    localparam int MD_SCHED = 1;
    localparam int MD_TURN = 2;
    localparam int MD_WIN = 3;
    localparam int MD_LOSE = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [LEN_W-1:0] start_len = '0;
    logic key_valid = 1'b0;
    logic [TILE_W-1:0] key_tile = '0;
    logic flash_valid;
    logic [TILE_W-1:0] flash_tile;
    logic player_turn;
    logic [LEN_W-1:0] level;
    logic win;
    logic lose;
    logic [2:0] dbg_state;

    always #5 clock = ~clock;

    seq_game_engine #(
        .TILE_W(TILE_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
        .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .TIMEOUT_CYCLES(TO_C), .SEED(SEED)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .start_len(start_len),
        .key_valid(key_valid), .key_tile(key_tile),
        .flash_valid(flash_valid), .flash_tile(flash_tile),
        .player_turn(player_turn), .level(level), .win(win), .lose(lose),
        .dbg_state(dbg_state)
    );

    int check_count = 0;
    int error_count = 0;

    // ---------------- reference model ----------------
    logic [EXP_W-1:0]  exp_q[$];
    logic [TILE_W-1:0] m_seq[$];
    logic [15:0]       m_lfsr;
    logic [EXP_W-1:0]  m_exp;
    logic              m_valid = 1'b0;
    int m_mode = MD_IDLE;
    int m_len = 0;
    int m_idx = 0;
    int m_since = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int clamp_len(input int v);
        if (v < 1) return 1;
        if (v > MAX_LEN) return MAX_LEN;
        return v;
    endfunction

    function automatic logic [EXP_W-1:0] pack(input logic fv, input logic [TILE_W-1:0] t,
                                              input logic pt, input logic w, input logic l,
                                              input int lv);
        return {fv, t, pt, w, l, LEN_W'(lv)};
    endfunction

    task automatic push_dark(input int lv, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pack(1'b0, '0, 1'b0, 1'b0, 1'b0, lv));
    endtask

    task automatic push_playback();
        for (int i = 0; i < m_len; i++) begin
            for (int j = 0; j < ON_C; j++) exp_q.push_back(pack(1'b1, m_seq[i], 1'b0, 1'b0, 1'b0, m_len));
            push_dark(m_len, OFF_C);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1'b1;
            m_lfsr = SEED;
            m_mode = MD_IDLE;
            m_len = 0;
            m_idx = 0;
            m_since = 0;
            exp_q.delete();
            m_seq.delete();
        end else if (m_valid) begin
            m_lfsr = lfsr_step(m_lfsr);
            case (m_mode)
                MD_IDLE, MD_WIN, MD_LOSE: begin
                    if (start) begin
                        logic [15:0] l;
                        m_len = clamp_len(int'(start_len));
                        m_seq.delete();
                        l = m_lfsr;
                        for (int i = 0; i < m_len; i++) begin
                            m_seq.push_back(l[TILE_W-1:0]);
                            l = lfsr_step(l);
                        end
                        push_dark(m_len, m_len);
                        push_playback();
                        m_mode = MD_SCHED;
                    end
                end
                MD_TURN: begin
                    if (key_valid) begin
                        if (key_tile != m_seq[m_idx]) begin
                            m_mode = MD_LOSE;
                        end else if (m_idx < m_len - 1) begin
                            m_idx++;
                            m_since = 0;
                        end else if (m_len == MAX_LEN) begin
                            m_mode = MD_WIN;
                        end else begin
                            push_dark(m_len, 1);
                            m_seq.push_back(m_lfsr[TILE_W-1:0]);
                            m_len++;
                            push_dark(m_len, OFF_C);
                            push_playback();
                            m_mode = MD_SCHED;
                        end
                    end else begin
                        m_since++;
                        if (m_since == TO_C) m_mode = MD_LOSE;
                    end
                end
                default: ;
            endcase
        end
        if (m_valid) begin
            if (m_mode == MD_SCHED && exp_q.size() == 0) begin
                m_mode = MD_TURN;
                m_idx = 0;
                m_since = 0;
            end
            case (m_mode)
                MD_SCHED: m_exp = exp_q.pop_front();
                MD_TURN:  m_exp = pack(1'b0, '0, 1'b1, 1'b0, 1'b0, m_len);
                MD_WIN:   m_exp = pack(1'b0, '0, 1'b0, 1'b1, 1'b0, m_len);
                MD_LOSE:  m_exp = pack(1'b0, '0, 1'b0, 1'b0, 1'b1, m_len);
                default:  m_exp = pack(1'b0, '0, 1'b0, 1'b0, 1'b0, m_len);
            endcase
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clock) begin
        if (m_valid) begin
            logic [EXP_W-1:0] act;
            act = {flash_valid, flash_tile, player_turn, win, lose, level};
            check_count++;
            if (act !== m_exp) begin
                error_count++;
                $display("FAIL cycle_outputs t=%0t actual fv=%0d tile=%0d turn=%0d win=%0d lose=%0d level=%0d required fv=%0d tile=%0d turn=%0d win=%0d lose=%0d level=%0d",
                         $time, act[EXP_W-1], act[EXP_W-2 -: TILE_W], act[LEN_W+2], act[LEN_W+1],
                         act[LEN_W], act[LEN_W-1:0], m_exp[EXP_W-1], m_exp[EXP_W-2 -: TILE_W],
                         m_exp[LEN_W+2], m_exp[LEN_W+1], m_exp[LEN_W], m_exp[LEN_W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_lit(input string name, input int act, input int req);
        check_count++;
        if (act != req) begin
            error_count++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic start_game(input int len);
        start = 1'b1;
        start_len = LEN_W'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [TILE_W-1:0] t);
        key_valid = 1'b1;
        key_tile = t;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_turn();
        int n = 0;
        while (m_mode != MD_TURN && n < 400) begin
            tick();
            n++;
        end
        if (m_mode != MD_TURN) check_lit("wait_turn_budget", 0, 1);
    endtask

    task automatic play_round();
        int l = m_len;
        for (int i = 0; i < l; i++) press(m_seq[i]);
    endtask

    task automatic wait_flash();
        int n = 0;
        while (!flash_valid && n < 200) begin
            tick();
            n++;
        end
        check_lit("wait_flash_budget", int'(flash_valid), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int h;
        int lo;
        int r;
        repeat (3) tick();
        check_lit("reset_flash_valid", int'(flash_valid), 0);
        check_lit("reset_level", int'(level), 0);
        check_lit("reset_win", int'(win), 0);
        check_lit("reset_lose", int'(lose), 0);
        check_lit("reset_turn", int'(player_turn), 0);
        reset = 1'b0;
        tick();

        // Playback timing with start_len=3.
        start_game(3);
        check_lit("level_after_start3", int'(level), 3);
        n = 1;
        while (!flash_valid && n < 50) begin
            tick();
            n++;
        end
        check_lit("first_flash_delay", n, 4);
        for (int p = 0; p < 3; p++) begin
            h = 0;
            while (flash_valid && h < 20) begin
                tick();
                h++;
            end
            check_lit("pulse_high_cycles", h, ON_C);
            lo = 0;
            while (!flash_valid && !player_turn && lo < 20) begin
                tick();
                lo++;
            end
            check_lit("pulse_low_cycles", lo, OFF_C);
        end
        check_lit("turn_after_last_gap", int'(player_turn), 1);

        // start during WAIT_KEY is ignored; a same-cycle key is processed.
        start = 1'b1;
        start_len = LEN_W'(1);
        press(m_seq[0]);
        start = 1'b0;
        check_lit("start_in_turn_level", int'(level), 3);
        check_lit("start_in_turn_turn", int'(player_turn), 1);
        press(m_seq[1]);
        press(m_seq[2]);
        // Key during SHOW_ON is dropped.
        wait_flash();
        press(TILE_W'($urandom_range(0, 3)));
        wait_turn();
        check_lit("level_after_append", int'(level), 4);
        play_round();
        check_lit("win_after_max", int'(win), 1);
        check_lit("win_turn_low", int'(player_turn), 0);

        // Full win from start_len=2.
        start_game(2);
        check_lit("win_flag_drops", int'(win), 0);
        check_lit("level_2", int'(level), 2);
        wait_turn();
        play_round();
        wait_turn();
        check_lit("level_3", int'(level), 3);
        play_round();
        wait_turn();
        check_lit("level_4", int'(level), 4);
        play_round();
        check_lit("full_win", int'(win), 1);

        // Wrong key.
        start_game(1);
        wait_turn();
        press(TILE_W'(m_seq[0] + 1'b1));
        check_lit("wrong_key_lose", int'(lose), 1);
        press(m_seq[0]);
        check_lit("lose_sticky", int'(lose), 1);

        // Timeout restarted by a correct key at turn cycle 9.
        start_game(2);
        wait_turn();
        repeat (9) tick();
        press(m_seq[0]);
        check_lit("no_lose_after_key", int'(lose), 0);
        n = 0;
        while (!lose && n < 40) begin
            tick();
            n++;
        end
        check_lit("timeout_after_key", n, TO_C);

        // Plain timeout.
        start_game(2);
        wait_turn();
        n = 0;
        while (!lose && n < 40) begin
            tick();
            n++;
        end
        check_lit("timeout_no_keys", n, TO_C);

        // Length clamps.
        start_game(0);
        check_lit("clamp_low", int'(level), 1);
        wait_turn();
        press(TILE_W'(m_seq[0] + 1'b1));
        start_game(9);
        check_lit("clamp_high", int'(level), MAX_LEN);

        // Reset in the middle of SHOW_ON.
        wait_flash();
        tick();
        reset = 1'b1;
        tick();
        check_lit("midshow_reset_flash", int'(flash_valid), 0);
        check_lit("midshow_reset_level", int'(level), 0);
        check_lit("midshow_reset_win", int'(win), 0);
        check_lit("midshow_reset_lose", int'(lose), 0);
        reset = 1'b0;

        // Randomized play, checked cycle by cycle by the model.
        for (int c = 0; c < 8000; c++) begin
            start = 1'b0;
            key_valid = 1'b0;
            reset = ($urandom_range(0, 2999) == 0);
            if (m_mode == MD_IDLE || m_mode == MD_WIN || m_mode == MD_LOSE) begin
                if ($urandom_range(0, 3) == 0) begin
                    start = 1'b1;
                    start_len = LEN_W'($urandom_range(0, 6));
                end
            end else begin
                if ($urandom_range(0, 30) == 0) begin
                    start = 1'b1;
                    start_len = LEN_W'($urandom_range(0, 6));
                end
                if (m_mode == MD_TURN) begin
                    r = $urandom_range(0, 99);
                    if (r < 30) begin
                        key_valid = 1'b1;
                        key_tile = m_seq[m_idx];
                    end else if (r < 32) begin
                        key_valid = 1'b1;
                        key_tile = TILE_W'(m_seq[m_idx] + 1'b1);
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    key_valid = 1'b1;
                    key_tile = TILE_W'($urandom_range(0, 3));
                end
            end
            tick();
        end
        start = 1'b0;
        key_valid = 1'b0;
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
